cdc_hs_rx: RTL and testbench



---
 rtl/cdc_pkg.sv | 24 ++
 rtl/cdc_sync_bit.sv | 33 +++
 rtl/cdc_hs_rx.sv | 202 ++++++++++++++++++++
 tb/tb_cdc_hs_rx.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// ----------------------------------------------------------------------------
// cdc_pkg
// Shared types and constants for the toggle request/acknowledge CDC receiver.
//   ch_st_e             : per-channel receive state
//   CDC_SYNC_STAGES_MIN : smallest usable synchroniser depth
//   cdc_chw()           : width of a channel index, never less than one bit
// ----------------------------------------------------------------------------
package cdc_pkg;

   typedef enum logic [1:0] {
      CH_IDLE = 2'd0,
      CH_HOLD = 2'd1,
      CH_OUT  = 2'd2
   } ch_st_e;

   localparam int CDC_SYNC_STAGES_MIN = 2;

   // A single channel still needs a one-bit index so dest_ch never collapses
   // to a zero-width port.
   function automatic int cdc_chw(input int nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// ----------------------------------------------------------------------------
// cdc_sync_bit
// Multi-flop synchroniser for one asynchronous level (here a request toggle).
// Ports:
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, chain clears to 0
//   d     : asynchronous input
//   q     : synchronised output, STAGES clock edges behind d
// ----------------------------------------------------------------------------
module cdc_sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   // Shift the asynchronous input through the chain; only the last flop is
   // used by downstream logic so metastability has STAGES-1 cycles to settle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/cdc_hs_rx.sv
// ----------------------------------------------------------------------------
// cdc_hs_rx
// Destination side of a multi-channel toggle request/acknowledge CDC. Each
// channel's request toggle is synchronised, the source-held data word is
// captured into a per-channel hold register, and the held words are merged
// round-robin onto a single valid/ready stream. Each delivered word flips the
// channel's ack toggle back to the source.
//
// Ports:
//   dest_clk     : destination clock, every flop in this block
//   dest_rstn    : asynchronous active-low reset
//   src_req_tgl  : per-channel async request toggle, one flip per transfer
//   src_data     : per-channel data, held stable by the source until ack
//   dest_ack_tgl : per-channel ack toggle, straight from a flop
//   dest_valid   : output word valid
//   dest_ready   : consumer ready
//   dest_ch      : channel index of dest_data
//   dest_data    : output word
//
// Optional build macro CDC_HS_RX_PARITY_EN adds:
//   src_par      : per-channel even parity bit for the src_data word
//   dest_perr    : parity error flag travelling with dest_data
// ----------------------------------------------------------------------------
module cdc_hs_rx
   import cdc_pkg::*;
#(
   parameter  int W           = 32,
   parameter  int NCH         = 4,
   parameter  int SYNC_STAGES = 2,
   localparam int CHW         = cdc_chw(NCH)
) (
   input  logic               dest_clk,
   input  logic               dest_rstn,
   input  logic [NCH-1:0]     src_req_tgl,
   input  logic [NCH*W-1:0]   src_data,
`ifdef CDC_HS_RX_PARITY_EN
   input  logic [NCH-1:0]     src_par,
   output logic               dest_perr,
`endif
   output logic [NCH-1:0]     dest_ack_tgl,
   output logic               dest_valid,
   input  logic               dest_ready,
   output logic [CHW-1:0]     dest_ch,
   output logic [W-1:0]       dest_data
);

   logic [NCH-1:0] sync;
   logic [NCH-1:0] seen_q;
   ch_st_e         st_q [NCH];
   ch_st_e         st_d [NCH];
   logic [W-1:0]   hold_q [NCH];
   logic [CHW-1:0] rr_q;

   logic [NCH-1:0] capture;
   logic [NCH-1:0] out_oh;
   logic [NCH-1:0] grant_oh;
   logic [CHW-1:0] grant_idx;
   logic [CHW-1:0] rr_d;
   logic [W-1:0]   sel_data;
   logic           any_hold;
   logic           fire;
   logic           load;
   int             idx;
   int             nxt;

`ifdef CDC_HS_RX_PARITY_EN
   logic [NCH-1:0] hold_perr_q;
   logic           sel_perr;
`endif

   // One synchroniser per channel request toggle.
   for (genvar g = 0; g < NCH; g++) begin : g_sync
      cdc_sync_bit #(
         .STAGES (SYNC_STAGES)
      ) u_sync (
         .clk   (dest_clk),
         .rst_n (dest_rstn),
         .d     (src_req_tgl[g]),
         .q     (sync[g])
      );
   end

   // Channel state register.
   always_ff @(posedge dest_clk or negedge dest_rstn) begin
      if (!dest_rstn) begin
         for (int c = 0; c < NCH; c++) begin
            st_q[c] <= CH_IDLE;
         end
      end else begin
         for (int c = 0; c < NCH; c++) begin
            st_q[c] <= st_d[c];
         end
      end
   end

   // Channel next-state. Only one channel can sit in CH_OUT (the one owning
   // the output register), so a fire always retires exactly that channel.
   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         st_d[c] = st_q[c];
         unique case (st_q[c])
            CH_IDLE: if (capture[c])              st_d[c] = CH_HOLD;
            CH_HOLD: if (load && grant_oh[c])     st_d[c] = CH_OUT;
            CH_OUT:  if (fire)                    st_d[c] = CH_IDLE;
            default:                              st_d[c] = CH_IDLE;
         endcase
      end
   end

   // Channel-derived control: capture strobes, the round-robin grant and the
   // output-register load. A toggle mismatch seen while a channel is busy is
   // simply left pending and picked up once that channel is idle again.
   always_comb begin
      fire      = dest_valid & dest_ready;
      capture   = '0;
      out_oh    = '0;
      grant_oh  = '0;
      grant_idx = '0;
      rr_d      = rr_q;
      sel_data  = '0;
      any_hold  = 1'b0;
      idx       = 0;
      nxt       = 0;
`ifdef CDC_HS_RX_PARITY_EN
      sel_perr  = 1'b0;
`endif
      for (int c = 0; c < NCH; c++) begin
         capture[c] = (st_q[c] == CH_IDLE) && (sync[c] != seen_q[c]);
         out_oh[c]  = (st_q[c] == CH_OUT);
      end
      for (int i = 0; i < NCH; i++) begin
         idx = int'(rr_q) + i;
         if (idx >= NCH) begin
            idx = idx - NCH;
         end
         if (!any_hold && (st_q[idx] == CH_HOLD)) begin
            any_hold      = 1'b1;
            grant_oh[idx] = 1'b1;
            grant_idx     = CHW'(idx);
            nxt           = idx + 1;
            if (nxt >= NCH) begin
               nxt = 0;
            end
            rr_d          = CHW'(nxt);
         end
      end
      for (int c = 0; c < NCH; c++) begin
         if (grant_oh[c]) begin
            sel_data = hold_q[c];
`ifdef CDC_HS_RX_PARITY_EN
            sel_perr = hold_perr_q[c];
`endif
         end
      end
      load = (!dest_valid || fire) && any_hold;
   end

   // Datapath: capture into hold, load the output register, flip acks.
   // A fire and a fresh load share an edge, giving one word per cycle.
   always_ff @(posedge dest_clk or negedge dest_rstn) begin
      if (!dest_rstn) begin
         seen_q       <= '0;
         rr_q         <= '0;
         dest_valid   <= 1'b0;
         dest_ch      <= '0;
         dest_data    <= '0;
         dest_ack_tgl <= '0;
         for (int c = 0; c < NCH; c++) begin
            hold_q[c] <= '0;
         end
`ifdef CDC_HS_RX_PARITY_EN
         hold_perr_q  <= '0;
         dest_perr    <= 1'b0;
`endif
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (capture[c]) begin
               hold_q[c] <= src_data[c*W +: W];
               seen_q[c] <= sync[c];
`ifdef CDC_HS_RX_PARITY_EN
               hold_perr_q[c] <= (^src_data[c*W +: W]) ^ src_par[c];
`endif
            end
         end
         if (load) begin
            dest_valid <= 1'b1;
            dest_ch    <= grant_idx;
            dest_data  <= sel_data;
            rr_q       <= rr_d;
`ifdef CDC_HS_RX_PARITY_EN
            dest_perr  <= sel_perr;
`endif
         end else if (fire) begin
            dest_valid <= 1'b0;
         end
         if (fire) begin
            dest_ack_tgl <= dest_ack_tgl ^ out_oh;
         end
      end
   end

endmodule

// File: tb/tb_cdc_hs_rx.sv
// ----------------------------------------------------------------------------
// tb_cdc_hs_rx
// Self-checking bench for cdc_hs_rx. A source model owns one outstanding word
// per channel; the scoreboard remembers that word and checks it against what
// arrives on the output stream, along with the ack toggle each channel should
// show, output stability under backpressure, latency and arbitration order.
// Build with CDC_HS_RX_PARITY_EN to also exercise the parity path.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cdc_hs_rx;

   localparam int W   = 32;
   localparam int NCH = 4;
   localparam int SS  = 2;
   localparam int CHW = 2;

   logic             dest_clk = 1'b0;
   logic             dest_rstn;
   logic [NCH-1:0]   src_req_tgl;
   logic [NCH*W-1:0] src_data;
   logic [NCH-1:0]   dest_ack_tgl;
   logic             dest_valid;
   logic             dest_ready;
   logic [CHW-1:0]   dest_ch;
   logic [W-1:0]     dest_data;
`ifdef CDC_HS_RX_PARITY_EN
   logic [NCH-1:0]   src_par;
   logic             dest_perr;
   logic             exp_perr [NCH];
   logic             stall_perr;
`endif

   int             errors = 0;
   int             checks = 0;
   int             cycle  = 0;
   logic [W-1:0]   exp_word [NCH];
   logic [NCH-1:0] pending;
   logic [NCH-1:0] exp_ack;
   int             fire_cnt [NCH];
   int             fire_ch_q [$];
   int             fire_cyc_q [$];
   logic           stalled;
   logic [CHW-1:0] stall_ch;
   logic [W-1:0]   stall_data;
   int             base;

   cdc_hs_rx #(
      .W           (W),
      .NCH         (NCH),
      .SYNC_STAGES (SS)
   ) dut (
      .dest_clk     (dest_clk),
      .dest_rstn    (dest_rstn),
      .src_req_tgl  (src_req_tgl),
      .src_data     (src_data),
`ifdef CDC_HS_RX_PARITY_EN
      .src_par      (src_par),
      .dest_perr    (dest_perr),
`endif
      .dest_ack_tgl (dest_ack_tgl),
      .dest_valid   (dest_valid),
      .dest_ready   (dest_ready),
      .dest_ch      (dest_ch),
      .dest_data    (dest_data)
   );

   // Free-running destination clock.
   always #5 dest_clk = ~dest_clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, expv, cycle);
      end
   endtask

   // Source side of one transfer: present the word, flip the request toggle
   // and remember what the receiver owes us on that channel.
   task automatic sendWord(input int c, input logic [W-1:0] d, input logic bad_par);
      src_data[c*W +: W] = d;
`ifdef CDC_HS_RX_PARITY_EN
      src_par[c]  = (^d) ^ bad_par;
      exp_perr[c] = bad_par;
`else
      if (bad_par) begin
         $display("[TB] note: parity request ignored in this build");
      end
`endif
      src_req_tgl[c] = ~src_req_tgl[c];
      exp_word[c]    = d;
      pending[c]     = 1'b1;
   endtask

   // One clock cycle: check the state left by the last edge, choose ready,
   // score the word that will fire on the coming edge, then advance.
   task automatic applyStimulus(input logic rdy);
      int c;
      checkOutput("ack_tgl", dest_ack_tgl, exp_ack);
      if (stalled) begin
         checkOutput("stall_valid", dest_valid, 1);
         checkOutput("stall_ch", dest_ch, stall_ch);
         checkOutput("stall_data", dest_data, stall_data);
`ifdef CDC_HS_RX_PARITY_EN
         checkOutput("stall_perr", dest_perr, stall_perr);
`endif
      end
      dest_ready = rdy;
      if (dest_valid && rdy) begin
         c = int'(dest_ch);
         checkOutput("fire_pending", pending[c], 1);
         checkOutput("fire_data", dest_data, exp_word[c]);
`ifdef CDC_HS_RX_PARITY_EN
         checkOutput("fire_perr", dest_perr, exp_perr[c]);
`endif
         pending[c] = 1'b0;
         exp_ack[c] = ~exp_ack[c];
         fire_cnt[c]++;
         fire_ch_q.push_back(c);
         fire_cyc_q.push_back(cycle);
      end
      stalled    = dest_valid && !rdy;
      stall_ch   = dest_ch;
      stall_data = dest_data;
`ifdef CDC_HS_RX_PARITY_EN
      stall_perr = dest_perr;
`endif
      @(posedge dest_clk);
      #1;
      cycle++;
   endtask

   task automatic waitIdle(input int c);
      for (int n = 0; n < 50 && dest_ack_tgl[c] !== src_req_tgl[c]; n++) begin
         applyStimulus(1'b1);
      end
      checkOutput("idle_wait", dest_ack_tgl[c], src_req_tgl[c]);
   endtask

   task automatic waitValid(input logic rdy);
      for (int n = 0; n < 20 && !dest_valid; n++) begin
         applyStimulus(rdy);
      end
      checkOutput("wait_valid", dest_valid, 1);
   endtask

   task automatic drain();
      for (int n = 0; n < 100 && pending != '0; n++) begin
         applyStimulus(1'b1);
      end
      checkOutput("drain_pending", pending, 0);
   endtask

   initial begin
      dest_rstn   = 1'b0;
      dest_ready  = 1'b0;
      src_req_tgl = '0;
      src_data    = '0;
      pending     = '0;
      exp_ack     = '0;
      stalled     = 1'b0;
      stall_ch    = '0;
      stall_data  = '0;
      for (int c = 0; c < NCH; c++) begin
         fire_cnt[c] = 0;
         exp_word[c] = '0;
      end
`ifdef CDC_HS_RX_PARITY_EN
      src_par    = '0;
      stall_perr = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         exp_perr[c] = 1'b0;
      end
`endif

      // Reset values.
      repeat (3) @(posedge dest_clk);
      #1;
      checkOutput("rst_valid", dest_valid, 0);
      checkOutput("rst_ack", dest_ack_tgl, 0);
      checkOutput("rst_ch", dest_ch, 0);
      checkOutput("rst_data", dest_data, 0);
`ifdef CDC_HS_RX_PARITY_EN
      checkOutput("rst_perr", dest_perr, 0);
`endif
      dest_rstn = 1'b1;
      @(posedge dest_clk);
      #1;

      // Single transfer and latency: valid appears after edge 3.
      $display("[TB] single transfer");
      sendWord(0, 32'hDEADBEEF, 1'b0);
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      checkOutput("lat_valid_e2", dest_valid, 0);
      applyStimulus(1'b1);
      checkOutput("lat_valid_e3", dest_valid, 1);
      checkOutput("lat_ch", dest_ch, 0);
      checkOutput("lat_data", dest_data, 32'hDEADBEEF);
      applyStimulus(1'b1);
      checkOutput("single_ack0", dest_ack_tgl[0], 1);
      checkOutput("single_valid_off", dest_valid, 0);

      // Back-to-back on ch2: next request as soon as the ack returns.
      $display("[TB] back-to-back ch2");
      base = fire_cnt[2];
      for (int k = 0; k < 8; k++) begin
         waitIdle(2);
         sendWord(2, W'(k), 1'b0);
      end
      drain();
      checkOutput("b2b_count", fire_cnt[2] - base, 8);

      // Simultaneous requests: a ch3 transfer first leaves the pointer at 0.
      $display("[TB] simultaneous");
      sendWord(3, 32'h55, 1'b0);
      drain();
      fire_ch_q.delete();
      fire_cyc_q.delete();
      for (int c = 0; c < NCH; c++) begin
         sendWord(c, W'(32'hA0 + c), 1'b0);
      end
      drain();
      checkOutput("sim_count", fire_ch_q.size(), 4);
      for (int i = 0; i < fire_ch_q.size(); i++) begin
         checkOutput("sim_order", fire_ch_q[i], i);
         if (i > 0) begin
            checkOutput("sim_consec", fire_cyc_q[i] - fire_cyc_q[i-1], 1);
         end
      end

      // Backpressure: ch1 held for 10 cycles while ch3 arrives behind it.
      $display("[TB] backpressure");
      sendWord(1, 32'h1111_2222, 1'b0);
      waitValid(1'b0);
      for (int k = 0; k < 10; k++) begin
         if (k == 2) begin
            sendWord(3, 32'h3333_4444, 1'b0);
         end
         applyStimulus(1'b0);
      end
      checkOutput("bp_ch", dest_ch, 1);
      checkOutput("bp_data", dest_data, 32'h1111_2222);
      applyStimulus(1'b1);
      checkOutput("bp_next_valid", dest_valid, 1);
      checkOutput("bp_next_ch", dest_ch, 3);
      drain();

      // Reset with ch0 owning the output and ch1 sitting in hold.
      $display("[TB] reset mid-operation");
      sendWord(0, 32'h0A0A_0A0A, 1'b0);
      waitValid(1'b0);
      sendWord(1, 32'h0B0B_0B0B, 1'b0);
      applyStimulus(1'b0);
      applyStimulus(1'b0);
      applyStimulus(1'b0);
      dest_rstn   = 1'b0;
      src_req_tgl = '0;
      #1;
      checkOutput("mid_rst_valid", dest_valid, 0);
      checkOutput("mid_rst_ack", dest_ack_tgl, 0);
      checkOutput("mid_rst_ch", dest_ch, 0);
      checkOutput("mid_rst_data", dest_data, 0);
      pending = '0;
      exp_ack = '0;
      stalled = 1'b0;
      @(posedge dest_clk);
      #1;
      dest_rstn = 1'b1;
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b1);
         checkOutput("post_rst_valid", dest_valid, 0);
      end

`ifdef CDC_HS_RX_PARITY_EN
      // Parity: a bad word is flagged, the following good word is not.
      $display("[TB] parity");
      sendWord(0, 32'h1, 1'b1);
      waitValid(1'b0);
      checkOutput("par_bad", dest_perr, 1);
      applyStimulus(1'b1);
      waitIdle(0);
      sendWord(0, 32'h1, 1'b0);
      waitValid(1'b0);
      checkOutput("par_good", dest_perr, 0);
      drain();
`endif

      // Random traffic on all channels with random consumer stalls.
      $display("[TB] random traffic");
      for (int n = 0; n < 3000; n++) begin
         for (int c = 0; c < NCH; c++) begin
            if (!pending[c] && dest_ack_tgl[c] === src_req_tgl[c] && $urandom_range(0, 1) == 1) begin
               sendWord(c, $urandom, ($urandom_range(0, 3) == 0));
            end
         end
         applyStimulus($urandom_range(0, 3) != 0);
      end
      drain();
      applyStimulus(1'b1);
      checkOutput("final_valid", dest_valid, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
